// File: rtl/fb_scanout.sv
// Framebuffer scanout reader: fetches 8bpp indexed words from DDRAM into a small FIFO,
// expands them to pixels through a 256-entry RGB888 palette, aligned with hvgen syncs.
module fb_scanout #(
  parameter int unsigned WIDTH      = 720,
  parameter int unsigned HEIGHT     = 480,
  parameter logic [28:0] BASE       = 29'h0600_0000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        ce_pix,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  output logic [28:0] ch_addr,
  output logic        ch_req,
  output logic        ch_rnw,
  input  logic        ch_ready,
  input  logic [63:0] ch_dout,
  input  logic        pal_wr,
  input  logic [7:0]  pal_addr,
  input  logic [23:0] pal_din,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic        underflow
);

  localparam int unsigned WORDS = WIDTH * HEIGHT / 8;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned WCW   = $clog2(WORDS + 1);
  localparam logic [WCW-1:0] WORDS_L = WCW'(WORDS);
  localparam logic [PW:0]    DEPTH_L = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state;
  logic            discard;
  logic            vs_d;
  logic            frame_start;
  logic [WCW-1:0]  word_cnt;

  logic [63:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     fifo_count;
  logic [2:0]      byte_idx;
  logic            fifo_empty;
  logic            px_en;
  logic            push;
  logic            pop;
  logic [63:0]     head;
  logic [7:0]      sel_byte;

  logic [23:0]     pal_mem [256];
  logic [23:0]     pal_q;
  logic            hs1, vs1, de1, vis1;

  assign ch_rnw      = 1'b1;
  assign frame_start = vs_in & ~vs_d;
  assign fifo_empty  = (fifo_count == '0);
  assign px_en       = ce_pix & de_in;
  assign push        = (state == S_WAIT) & ch_ready & ~discard & ~frame_start;
  assign pop         = px_en & ~fifo_empty & (byte_idx == 3'd7);
  assign head        = fifo_mem[rd_ptr];
  assign sel_byte    = head[{byte_idx, 3'b000} +: 8];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) vs_d <= 1'b0;
    else        vs_d <= vs_in;
  end

  // A frame start in IDLE flushes and issues the BASE request on the same edge;
  // in WAIT the outstanding read belongs to the old frame and is dropped on arrival.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      discard  <= 1'b0;
      ch_req   <= 1'b0;
      ch_addr  <= BASE;
      word_cnt <= '0;
    end else begin
      ch_req <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (frame_start) begin
            ch_addr  <= BASE;
            word_cnt <= '0;
            ch_req   <= 1'b1;
            state    <= S_WAIT;
          end else if (word_cnt < WORDS_L && fifo_count < DEPTH_L) begin
            ch_req <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (frame_start) begin
            ch_addr  <= BASE;
            word_cnt <= '0;
            if (ch_ready) begin
              state   <= S_IDLE;
              discard <= 1'b0;
            end else begin
              discard <= 1'b1;
            end
          end else if (ch_ready) begin
            state   <= S_IDLE;
            discard <= 1'b0;
            if (!discard) begin
              ch_addr  <= ch_addr + 29'd1;
              word_cnt <= word_cnt + WCW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= ch_dout;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      byte_idx   <= '0;
      underflow  <= 1'b0;
    end else if (frame_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      byte_idx   <= '0;
      underflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fifo_count <= fifo_count + (PW + 1)'(1);
      else if (pop && !push) fifo_count <= fifo_count - (PW + 1)'(1);
      if (px_en && !fifo_empty) byte_idx <= byte_idx + 3'd1;
      if (px_en && fifo_empty)  underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (pal_wr) pal_mem[pal_addr] <= pal_din;
    if (ce_pix) pal_q <= pal_mem[sel_byte];
  end

  // Colour is held between pixel enables, but blanks as soon as de_in drops.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      de1    <= 1'b0;
      vis1   <= 1'b0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      de_out <= 1'b0;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      hs1    <= hs_in;
      vs1    <= vs_in;
      de1    <= de_in;
      hs_out <= hs1;
      vs_out <= vs1;
      de_out <= de1;
      if (ce_pix) vis1 <= de_in & ~fifo_empty;
      else        vis1 <= vis1 & de_in;
      {vga_r, vga_g, vga_b} <= vis1 ? pal_q : '0;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout with a one-outstanding-read DDRAM model; a reduced
// 64x6 frame keeps the full-frame run short.
module tb_fb_scanout;

  localparam int unsigned W     = 64;
  localparam int unsigned H     = 6;
  localparam int unsigned WORDS = W * H / 8;
  localparam logic [28:0] BASE  = 29'h0600_0000;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        ce_pix, hs_in, vs_in, de_in;
  logic [28:0] ch_addr;
  logic        ch_req, ch_rnw;
  logic        ch_ready = 1'b0;
  logic [63:0] ch_dout  = '0;
  logic        pal_wr;
  logic [7:0]  pal_addr;
  logic [23:0] pal_din;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        hs_out, vs_out, de_out, underflow;

  fb_scanout #(.WIDTH(W), .HEIGHT(H), .BASE(BASE), .FIFO_DEPTH(16)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ce_pix(ce_pix),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .ch_addr(ch_addr), .ch_req(ch_req), .ch_rnw(ch_rnw),
    .ch_ready(ch_ready), .ch_dout(ch_dout),
    .pal_wr(pal_wr), .pal_addr(pal_addr), .pal_din(pal_din),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .underflow(underflow)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  // DDRAM model state
  int          nreq = 0;
  logic [28:0] last_addr = '0;
  logic [28:0] paddr = '0;
  bit          pend = 0;
  bit          hold = 0;
  int          cnt = 0;
  int          lat = 5;
  int          mode = 0;
  int          pmode = 0;

  logic [23:0] pal_model [256];

  function automatic logic [63:0] word_of(input int md, input int off);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      case (md)
        0:       w[k*8 +: 8] = 8'((off * 8 + k) % 256);
        1:       w[k*8 +: 8] = (k < 2) ? 8'h05 : 8'h09;
        default: w[k*8 +: 8] = 8'(32 + k);
      endcase
    end
    return w;
  endfunction

  // Data is chosen by the mode in force when the request was issued, so a stale
  // response carries recognisably old-frame bytes.
  always @(negedge clk_sys) begin
    ch_ready = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend && !hold) begin
        if (cnt <= 1) begin
          ch_ready = 1'b1;
          ch_dout  = word_of(pmode, int'(paddr - BASE));
          pend     = 0;
        end else begin
          cnt--;
        end
      end
      if (ch_req) begin
        if (pend) begin
          n_cmp++;
          n_bad++;
          $display("FAIL req_overlap: second ch_req at addr %h while one outstanding, required none", ch_addr);
        end
        pend      = 1;
        cnt       = lat;
        paddr     = ch_addr;
        pmode     = mode;
        last_addr = ch_addr;
        nreq++;
      end
    end
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_px(input string name, input logic [23:0] rgb, input logic de);
    check(name, 64'({vga_r, vga_g, vga_b, de_out}), 64'({rgb, de}));
  endtask

  task automatic drive(input logic ce, input logic de, input logic hs);
    ce_pix = ce;
    de_in  = de;
    hs_in  = hs;
    tick();
  endtask

  typedef struct {
    logic        ce, de, hs;
    logic [23:0] rgb;
    logic        de_o, hs_o;
  } vec_t;

  vec_t        tbl [13];
  int          r0;
  bit          got;
  int          pixn;
  bit          pv;
  logic [23:0] pexp;

  initial begin
    rst_n = 1'b0; ce_pix = 1'b1; de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b0;
    pal_wr = 1'b0; pal_addr = '0; pal_din = '0;

    // Palette load while held in reset: palette[n] = {n,n,n}
    for (int n = 0; n < 256; n++) begin
      pal_wr   = 1'b1;
      pal_addr = 8'(n);
      pal_din  = {3{8'(n)}};
      pal_model[n] = {3{8'(n)}};
      tick();
    end
    pal_wr = 1'b0;

    check("rst_ch_req", 64'(ch_req), 64'd0);
    check("rst_ch_addr", 64'(ch_addr), 64'(BASE));
    check("rst_ch_rnw", 64'(ch_rnw), 64'd1);
    check("rst_rgb", 64'({vga_r, vga_g, vga_b}), 64'd0);
    check("rst_syncs", 64'({hs_out, vs_out, de_out}), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);

    ce_pix = 1'b0; de_in = 1'b0; hs_in = 1'b0;
    rst_n = 1'b1;
    tick();
    check("first_req", 64'(ch_req), 64'd1);
    check("first_addr", 64'(ch_addr), 64'(BASE));

    // FIFO fills to 16 words, then fetching stalls until a pop
    repeat (200) tick();
    check("fill_nreq", 64'(nreq), 64'd16);
    check("fill_last_addr", 64'(last_addr), 64'(BASE + 29'd15));

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 24'h010101, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 24'h020202, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 24'h030303, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 24'h040404, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 24'h040404, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 24'h050505, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 24'h060606, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 24'h070707, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 24'h080808, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};

    for (int i = 0; i <= 13; i++) begin
      if (i < 13) drive(tbl[i].ce, tbl[i].de, tbl[i].hs);
      else        drive(1'b0, 1'b0, 1'b0);
      if (i > 0)
        check($sformatf("vec%0d", i - 1),
              64'({vga_r, vga_g, vga_b, de_out, hs_out}),
              64'({tbl[i-1].rgb, tbl[i-1].de_o, tbl[i-1].hs_o}));
    end

    repeat (20) tick();
    check("refill_nreq", 64'(nreq), 64'd17);
    check("refill_last_addr", 64'(last_addr), 64'(BASE + 29'd16));
    check("no_underflow_yet", 64'(underflow), 64'd0);

    // Non-black palette[0] so forced black is distinguishable
    pal_wr = 1'b1; pal_addr = 8'd0; pal_din = 24'h112233; pal_model[0] = 24'h112233;
    tick();
    pal_wr = 1'b0;

    // Frame start from IDLE; DDRAM never answers
    hold = 1; mode = 2;
    vs_in = 1'b1;
    tick();
    check("fs_req", 64'(ch_req), 64'd1);
    check("fs_addr", 64'(ch_addr), 64'(BASE));

    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check_px("uf_px0", 24'h000000, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    check_px("uf_px1", 24'h000000, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check_px("uf_px2", 24'h000000, 1'b1);
    check("uf_set", 64'(underflow), 64'd1);

    // Frame start while the read is still outstanding
    vs_in = 1'b0;
    tick();
    tick();
    mode  = 1;
    vs_in = 1'b1;
    tick();
    check("uf_cleared", 64'(underflow), 64'd0);
    check("discard_no_req", 64'(ch_req), 64'd0);
    vs_in = 1'b0;

    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check_px("uf2_px0", 24'h000000, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check_px("uf2_px1", 24'h000000, 1'b1);
    check("uf2_set", 64'(underflow), 64'd1);

    r0 = nreq; got = 0; hold = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (nreq != r0) got = 1;
    end
    check("refetch_seen", 64'(got), 64'd1);
    check("refetch_addr", 64'(last_addr), 64'(BASE));
    repeat (30) tick();

    // Palette write racing a read of the same index
    pal_wr = 1'b1; pal_addr = 8'd5; pal_din = 24'hA5A5A5;
    drive(1'b1, 1'b1, 1'b0);
    pal_wr = 1'b0;
    pal_model[5] = 24'hA5A5A5;
    drive(1'b1, 1'b1, 1'b0);
    check_px("palwr_old", 24'h050505, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    check_px("palwr_new", 24'hA5A5A5, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check_px("byte2", 24'h090909, 1'b1);

    // Full frame: ce_pix every 2 clocks, 4-cycle DDRAM latency
    repeat (150) tick();
    mode = 0; lat = 4;
    r0 = nreq;
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
    for (int i = 0; i < 100; i++) drive(1'(i % 2 == 0), 1'b0, 1'b0);

    pixn = 0; pv = 0; pexp = '0;
    for (int ln = 0; ln < int'(H); ln++) begin
      for (int c = 0; c < int'((W + 8) * 2); c++) begin
        drive(1'(c % 2 == 0), 1'(c < int'(W * 2)), 1'(c >= int'(W * 2 + 4)));
        if (pv) check_px($sformatf("frame_px%0d", pixn - 1), pexp, 1'b1);
        pv = ce_pix & de_in;
        if (pv) begin
          pexp = pal_model[pixn % 256];
          pixn++;
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    repeat (50) tick();
    check("frame_nreq", 64'(nreq - r0), 64'(WORDS));
    check("frame_last_addr", 64'(last_addr), 64'(BASE + 29'(WORDS - 1)));
    check("frame_no_underflow", 64'(underflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
